// File: rtl/bch_encode_stream_if.sv
// Handshake bundle for bch_encode_stream.
//   master : message source / codeword sink (bench or upstream logic)
//   slave  : the encoder
// Signals:
//   in_valid/in_ready/in_data          message beats into the encoder
//   out_valid/out_ready/out_data       codeword beats out of the encoder
//   out_first/out_last/out_parity      codeword framing flags
//   abort                              only when BCH_ENCODE_ABORT_EN is defined
interface bch_encode_stream_if #(
    parameter int BITS = 1
);
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;
    logic            out_first;
    logic            out_last;
    logic            out_parity;
`ifdef BCH_ENCODE_ABORT_EN
    logic            abort;

    modport master (
        output in_valid, in_data, out_ready, abort,
        input  in_ready, out_valid, out_data, out_first, out_last, out_parity
    );
    modport slave (
        input  in_valid, in_data, out_ready, abort,
        output in_ready, out_valid, out_data, out_first, out_last, out_parity
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_last, out_parity
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_first, out_last, out_parity
    );
`endif
endinterface

// File: rtl/bch_encode_stream.sv
// Systematic streaming BCH encoder.
// Message beats pass straight through one output register while a BITS-wide
// parallel LFSR divides m(x)*x^ECC_BITS by g(x); the remainder is then
// emitted as parity beats, MSB first, in the order the decoder expects.
// g(x) is built at elaboration from P (LCM of the minimal polynomials of
// alpha^1..alpha^(2T-1) over GF(2^M)).
//
// Parameters:
//   P     packed BCH parameters (see BCH_PARAMS below)
//   BITS  bits per beat, 1..ECC_BITS
// Ports:
//   clk    clock, all logic on posedge
//   reset  synchronous, active-high
//   bus    bch_encode_stream_if.slave: in/out handshakes, data, framing flags
// Optional feature:
//   BCH_ENCODE_ABORT_EN  adds bus.abort, which drops the codeword in flight.

`ifndef BCH_PARAMS
`define BCH_PARAMS(m, t, db) ((32'(m) << 24) | (32'(t) << 16) | 32'(db))
`define BCH_M(p)             ((32'(p) >> 24) & 32'd255)
`define BCH_T(p)             ((32'(p) >> 16) & 32'd255)
`define BCH_DATA_BITS(p)     (32'(p) & 32'd65535)
`define BCH_ECC_BITS(p)      (`BCH_M(p) * `BCH_T(p))
`define BCH_SANE             `BCH_PARAMS(4, 2, 7)
`endif

module bch_encode_stream #(
    parameter logic [31:0] P    = `BCH_SANE,
    parameter int          BITS = 1
) (
    input logic                 clk,
    input logic                 reset,
    bch_encode_stream_if.slave  bus
);
    localparam int M         = int'(`BCH_M(P));
    localparam int T         = int'(`BCH_T(P));
    localparam int DATA_BITS = int'(`BCH_DATA_BITS(P));
    localparam int ECC_BITS  = int'(`BCH_ECC_BITS(P));
    localparam int N         = (1 << M) - 1;

    localparam int DATA_CYC = (DATA_BITS + BITS - 1) / BITS;
    localparam int PAR_CYC  = (ECC_BITS + BITS - 1) / BITS;
    localparam int R        = DATA_BITS - (DATA_CYC - 1) * BITS;
    localparam int CNT_MAX  = (DATA_CYC > PAR_CYC) ? DATA_CYC : PAR_CYC;
    localparam int CW       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    // ---------------------------------------------------------------
    // Elaboration-time field arithmetic
    // ---------------------------------------------------------------
    function automatic int prim_poly(int m);
        case (m)
            2:       return 'h7;
            3:       return 'hB;
            4:       return 'h13;
            5:       return 'h25;
            6:       return 'h43;
            7:       return 'h89;
            8:       return 'h11D;
            9:       return 'h211;
            10:      return 'h409;
            11:      return 'h805;
            12:      return 'h1053;
            13:      return 'h201B;
            14:      return 'h4443;
            15:      return 'h8003;
            default: return 'h1100B;
        endcase
    endfunction

    localparam int PRIM = prim_poly(M);

    function automatic int gf_mul(int a, int b);
        int r;
        int aa;
        r  = 0;
        aa = a;
        for (int i = 0; i < M; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ aa;
            aa = aa << 1;
            if (((aa >> M) & 1) != 0) aa = aa ^ PRIM;
        end
        return r;
    endfunction

    function automatic int gf_pow(int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = gf_mul(r, 2);
        return r;
    endfunction

    // One minimal polynomial per cyclotomic coset of the odd exponents;
    // even exponents share a coset with an odd one, so they add nothing.
    function automatic logic [ECC_BITS:0] gen_poly();
        logic [ECC_BITS:0]  g;
        logic [ECC_BITS:0]  prod;
        logic [M:0][15:0]   c;
        int                 e;
        int                 a;
        bit                 dup;
        bit                 done;
        g = '0;
        g[0] = 1'b1;
        for (int i = 1; i < 2 * T; i += 2) begin
            dup = 1'b0;
            for (int j = 1; j < i; j += 2) begin
                e = j;
                for (int k = 0; k < M; k++) begin
                    if (e == i) dup = 1'b1;
                    e = (e * 2) % N;
                end
            end
            if (!dup) begin
                c    = '0;
                c[0] = 16'd1;
                e    = i;
                a    = gf_pow(i);
                done = 1'b0;
                for (int s = 0; s < M; s++) begin
                    if (!done) begin
                        // c(x) *= (x + alpha^e)
                        for (int k = M; k >= 1; k--)
                            c[k] = c[k-1] ^ 16'(gf_mul(a, int'(c[k])));
                        c[0] = 16'(gf_mul(a, int'(c[0])));
                        e = (e * 2) % N;
                        a = gf_mul(a, a);
                        if (e == i) done = 1'b1;
                    end
                end
                // Coefficients are now 0/1: carry-less multiply into g.
                prod = '0;
                for (int k = 0; k <= M; k++)
                    if (c[k][0]) prod = prod ^ (g << k);
                g = prod;
            end
        end
        return g;
    endfunction

    localparam logic [ECC_BITS:0]   G     = gen_poly();
    localparam logic [ECC_BITS-1:0] G_LOW = G[ECC_BITS-1:0];

    function automatic logic [BITS-1:0] last_mask();
        logic [BITS-1:0] m;
        for (int i = 0; i < BITS; i++) m[i] = (i >= BITS - R);
        return m;
    endfunction

    localparam logic [BITS-1:0] LAST_MASK = last_mask();

    // Feed the top n bits of d (MSB first) through the divider.
    function automatic logic [ECC_BITS-1:0] lfsr_step(
        input logic [ECC_BITS-1:0] r,
        input logic [BITS-1:0]     d,
        input int                  n
    );
        logic [ECC_BITS-1:0] s;
        logic                fb;
        s = r;
        for (int i = 0; i < BITS; i++) begin
            if (i < n) begin
                fb = s[ECC_BITS-1] ^ d[BITS-1-i];
                s  = s << 1;
                if (fb) s = s ^ G_LOW;
            end
        end
        return s;
    endfunction

    // ---------------------------------------------------------------
    // Datapath / control
    // ---------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t              state;
    logic [ECC_BITS-1:0] lfsr;
    logic [CW-1:0]       cnt;

    logic                out_free;
    logic                accept;
    logic                last_data;
    logic                par_last;
    logic [ECC_BITS-1:0] lfsr_base;
    logic [ECC_BITS-1:0] lfsr_nxt;
    logic [BITS-1:0]     data_out;

    assign out_free = !bus.out_valid || bus.out_ready;
`ifdef BCH_ENCODE_ABORT_EN
    assign bus.in_ready = (state != PARITY) && out_free && !bus.abort;
`else
    assign bus.in_ready = (state != PARITY) && out_free;
`endif
    assign accept = bus.in_valid && bus.in_ready;

    // In IDLE the incoming beat is beat 0, so DATA_CYC==1 makes it the last.
    assign last_data = (state == IDLE) ? (DATA_CYC == 1) : (cnt == CW'(DATA_CYC - 1));
    assign par_last  = (cnt == CW'(PAR_CYC - 1));

    // A new codeword always divides from zero, whatever the register holds.
    assign lfsr_base = (state == IDLE) ? '0 : lfsr;
    assign lfsr_nxt  = last_data ? lfsr_step(lfsr_base, bus.in_data, R)
                                 : lfsr_step(lfsr_base, bus.in_data, BITS);
    // Bits past the message end are not part of the codeword; send zeros.
    assign data_out  = last_data ? (bus.in_data & LAST_MASK) : bus.in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lfsr           <= '0;
            cnt            <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.out_first  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_parity <= 1'b0;
`ifdef BCH_ENCODE_ABORT_EN
        end else if (bus.abort) begin
            state          <= IDLE;
            lfsr           <= '0;
            cnt            <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_first  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_data   <= data_out;
                        bus.out_first  <= (state == IDLE);
                        bus.out_last   <= 1'b0;
                        bus.out_parity <= 1'b0;
                        lfsr           <= lfsr_nxt;
                        if (last_data) begin
                            state <= PARITY;
                            cnt   <= '0;
                        end else begin
                            state <= DATA;
                            cnt   <= cnt + 1'b1;
                        end
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                PARITY: begin
                    // Remainder drains from the top; zeros shifted in below
                    // give the padding on a short final beat.
                    if (out_free) begin
                        bus.out_valid  <= 1'b1;
                        bus.out_data   <= lfsr[ECC_BITS-1 -: BITS];
                        bus.out_first  <= 1'b0;
                        bus.out_parity <= 1'b1;
                        bus.out_last   <= par_last;
                        if (par_last) begin
                            state <= IDLE;
                            cnt   <= '0;
                            lfsr  <= '0;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            lfsr  <= lfsr << BITS;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
